button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter N_BTN, default 5, giving the number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz), giving the required stable-input duration; legal minimum 2.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 50_000_000 (1 s at 50 MHz), giving the long-press threshold; legal minimum 1.
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means a pressed button drives 0.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port btn_in, input, N_BTN bits: raw asynchronous pin levels.
REQ-008 The block SHALL have port btn_level, output, N_BTN bits: debounced level, 1 = pressed; this port feeds the PIO input-port data.
REQ-009 The block SHALL have port press_pulse, output, N_BTN bits: one-cycle pulse per debounced press.
REQ-010 The block SHALL have port release_pulse, output, N_BTN bits: one-cycle pulse per debounced release.
REQ-011 The block SHALL have port hold_pulse, output, N_BTN bits: one-cycle pulse when a press has lasted HOLD_CYCLES.

Function
REQ-012 Each btn_in bit SHALL pass through a 2-flop synchronizer; raw_pressed = synchronized bit XOR ACTIVE_LOW.
REQ-013 Each channel SHALL run an independent FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a debounce counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 RELEASED: if raw_pressed, the FSM SHALL go to PRESS_WAIT with the counter set to 0.
REQ-015 PRESS_WAIT: if not raw_pressed, the FSM SHALL return to RELEASED (bounce rejected, no pulse); else if counter == DEBOUNCE_CYCLES-1, it SHALL go to PRESSED and assert press_pulse for one cycle; else the counter SHALL increment.
REQ-016 PRESSED: if not raw_pressed, the FSM SHALL go to RELEASE_WAIT with the counter set to 0.
REQ-017 RELEASE_WAIT SHALL mirror PRESS_WAIT: raw_pressed returns the FSM to PRESSED (no pulse, hold counter retained); DEBOUNCE_CYCLES stable-released cycles go to RELEASED and assert release_pulse for one cycle.
REQ-018 btn_level SHALL be a registered output, 1 exactly while the FSM is in PRESSED or RELEASE_WAIT.
REQ-019 Latency: with a clean edge, press_pulse and the btn_level rise SHALL occur exactly DEBOUNCE_CYCLES+2 clock edges after the first edge sampling btn_in pressed; release is symmetric.
REQ-020 A per-channel hold counter, cleared on entry to PRESSED from PRESS_WAIT, SHALL increment in PRESSED/RELEASE_WAIT, saturate at HOLD_CYCLES, and assert hold_pulse once, on the cycle it reaches HOLD_CYCLES; there SHALL be no repeat until a new press.
REQ-021 Channels SHALL be fully independent; any combination of pulses may be asserted in the same cycle.
REQ-022 press_pulse and release_pulse of one channel SHALL never be asserted in the same cycle; hold_pulse SHALL never be asserted outside PRESSED/RELEASE_WAIT.

Reset
REQ-023 Asynchronous reset SHALL set the synchronizer flops to the released level (ACTIVE_LOW value), every FSM to RELEASED, all counters to 0, and all outputs to 0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort without pulses; after release, a still-pressed button SHALL be re-qualified from RELEASED with full latency.

Structure
REQ-025 Package button_pkg SHALL hold the channel state enum and the default DEBOUNCE_CYCLES/HOLD_CYCLES constants.
REQ-026 Sub-module button_debounce_chan (synchronizer, FSM, counters, one channel) SHALL be instantiated N_BTN times by a generate loop in button_debounce.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=1, N_BTN=5)
REQ-027 Clean press: btn_in[0] 1->0 held -> press_pulse[0] high for exactly 1 cycle and btn_level[0]=1, both 6 edges after the first low sample.
REQ-028 Bounce: btn_in[1] low 3 cycles, high 1, low held -> no pulse during the glitch; press_pulse[1] fires 6 edges after the final low edge.
REQ-029 Hold: btn_in[2] low for 30 cycles -> exactly one hold_pulse[2], 10 cycles after press_pulse[2]; then release -> release_pulse[2] 6 edges after going high; btn_level[2]=0.
REQ-030 Release glitch: pressed channel 3 goes high 2 cycles then low -> btn_level[3] stays 1, no release_pulse, hold counter not reset.
REQ-031 Simultaneous: btn_in = 5'b00000 on one edge -> press_pulse = 5'b11111 in the same cycle.
REQ-032 Reset mid-press: assert reset_n=0 during PRESS_WAIT -> all outputs 0 immediately; after deassertion with the button held, press_pulse fires 6 edges later.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button debouncer.
// Defaults assume a 50 MHz clock: 20 ms debounce window, 1 s long-press threshold.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_HOLD_CYCLES     = 50_000_000;

endpackage

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM, hold counter and registered pulses.
module button_debounce_chan
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic              sync_p0;
    logic              sync_p1;
    logic              raw_pressed;
    btn_state_e        state;
    btn_state_e        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              level_d;
    logic              press_d;
    logic              release_d;
    logic              hold_d;

    // Synchronizer stages; reset to the idle pin level so no phantom press appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= ACTIVE_LOW;
            sync_p1 <= ACTIVE_LOW;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    assign raw_pressed = sync_p1 ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RELEASED;
            cnt      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (raw_pressed) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!raw_pressed) begin
                    state_next = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!raw_pressed) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (raw_pressed) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = RELEASED;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = RELEASED;
        endcase
    end

    // btn_level mirrors the current state, so level && level_d means "pressed now and next cycle".
    always_comb begin
        level_d       = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
        press_d       = (state == PRESS_WAIT) && (state_next == PRESSED);
        release_d     = (state == RELEASE_WAIT) && (state_next == RELEASED);
        hold_cnt_next = hold_cnt;
        hold_d        = 1'b0;
        if (press_d) begin
            hold_cnt_next = '0;
        end else if (btn_level && level_d && (hold_cnt != HOLD_MAX)) begin
            hold_cnt_next = hold_cnt + 1'b1;
            hold_d        = (hold_cnt_next == HOLD_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            hold_pulse    <= hold_d;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// N_BTN independent debounced button channels with press, release and long-press pulses.
module button_debounce
    import button_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] hold_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .btn_in        (btn_in[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .hold_pulse    (hold_pulse[i])
        );
    end

endmodule
